alu_scheduler: RTL and testbench

Shares the single clocked execution-unit ALU between two requesters (req0: main pipeline issue, req1: branch/address helper) using round-robin arbitration. It drives ALU operands, ALUControl and freeze, counts per-opcode latency, captures the result with flags, and returns it over a valid/ready response channel tagged with the requester id. It sits between the decode/issue stage and ALU inside the execution unit.

---
 rtl/alu_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_alu_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_scheduler
//  Description : Round-robin sharing of the execution-unit ALU between the
//                main issue pipeline (req0) and the branch/address helper
//                (req1). Drives ALU operands/control/freeze, times each op
//                by opcode latency, captures result and flags, and returns
//                them on a valid/ready response channel tagged with the id.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_scheduler #(
    parameter int LAT_BASE = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    // requester 0: main pipeline issue
    input  logic        req0_valid,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_unsigned,
    output logic        req0_ready,
    // requester 1: branch/address helper
    input  logic        req1_valid,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_unsigned,
    output logic        req1_ready,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    // ALU side
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [3:0]  alu_ctrl,
    output logic        alu_unsigned,
    output logic        alu_freeze,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        busy
);

    localparam logic [3:0] c_OP_NOP   = 4'b0000;
    localparam logic [3:0] c_OP_MUL   = 4'b0011;
    localparam logic [3:0] c_OP_DIV   = 4'b0100;
    localparam logic [3:0] c_LAT_BASE = 4'(LAT_BASE);
    localparam logic [3:0] c_LAT_MUL  = 4'(LAT_MUL);
    localparam logic [3:0] c_LAT_DIV  = 4'(LAT_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_last_id;     // requester granted most recently
    logic        r_exec_id;     // requester owning the op in flight
    logic        r_nop;         // op in flight is a NOP: ALU stays frozen
    logic [3:0]  r_count;

    logic [31:0] r_alu_inp1;
    logic [31:0] r_alu_inp2;
    logic [3:0]  r_alu_ctrl;
    logic        r_alu_unsigned;

    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_overflow;
    logic        r_rsp_zero;

    logic        w_window;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_sel_id;
    logic [3:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic        w_sel_unsigned;
    logic [3:0]  w_sel_lat;

    // Accept window, round-robin grant and selected request payload/latency
    always_comb begin
        w_window       = (r_state == ST_IDLE) || ((r_state == ST_DONE) && rsp_ready);
        // a tie goes to whichever requester was not granted last
        w_gnt0         = req0_valid && (!req1_valid || r_last_id);
        w_gnt1         = req1_valid && (!req0_valid || !r_last_id);
        // ready is forced low while reset is asserted
        w_accept       = reset_n && w_window && (w_gnt0 || w_gnt1);
        w_sel_id       = w_gnt1;
        w_sel_op       = w_gnt1 ? req1_op       : req0_op;
        w_sel_a        = w_gnt1 ? req1_a        : req0_a;
        w_sel_b        = w_gnt1 ? req1_b        : req0_b;
        w_sel_unsigned = w_gnt1 ? req1_unsigned : req0_unsigned;
        // a NOP spends one pass-through cycle so its response lands one edge
        // after acceptance, the same as a single-cycle op
        case (w_sel_op)
            c_OP_NOP: w_sel_lat = 4'd1;
            c_OP_MUL: w_sel_lat = c_LAT_MUL;
            c_OP_DIV: w_sel_lat = c_LAT_DIV;
            default:  w_sel_lat = c_LAT_BASE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_count == 4'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_next = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Issue registers, latency counter and response capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_id      <= 1'b1;
            r_exec_id      <= 1'b0;
            r_nop          <= 1'b0;
            r_count        <= 4'd0;
            r_alu_inp1     <= 32'd0;
            r_alu_inp2     <= 32'd0;
            r_alu_ctrl     <= 4'd0;
            r_alu_unsigned <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= 32'd0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
        end else if (w_accept) begin
            r_last_id      <= w_sel_id;
            r_exec_id      <= w_sel_id;
            r_nop          <= (w_sel_op == c_OP_NOP);
            r_count        <= w_sel_lat;
            r_alu_inp1     <= w_sel_a;
            r_alu_inp2     <= w_sel_b;
            r_alu_ctrl     <= w_sel_op;
            r_alu_unsigned <= w_sel_unsigned;
        end else if (r_state == ST_EXEC) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_rsp_id <= r_exec_id;
                if (r_nop) begin
                    r_rsp_result   <= 32'd0;
                    r_rsp_overflow <= 1'b0;
                    r_rsp_zero     <= 1'b1;
                end else begin
                    r_rsp_result   <= alu_result;
                    r_rsp_overflow <= alu_overflow;
                    r_rsp_zero     <= alu_zero;
                end
            end
        end
    end

    assign req0_ready   = w_accept && w_gnt0;
    assign req1_ready   = w_accept && w_gnt1;
    assign rsp_valid    = (r_state == ST_DONE);
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign alu_inp1     = r_alu_inp1;
    assign alu_inp2     = r_alu_inp2;
    assign alu_ctrl     = r_alu_ctrl;
    assign alu_unsigned = r_alu_unsigned;
    assign alu_freeze   = !((r_state == ST_EXEC) && !r_nop);
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_scheduler
//  Description : Self-checking bench for alu_scheduler with an ALU stand-in,
//                directed vector table, corner sequences and random traffic
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_scheduler;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_unsigned, req1_unsigned;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_zero;
    logic [31:0] alu_inp1, alu_inp2;
    logic [3:0]  alu_ctrl;
    logic        alu_unsigned, alu_freeze;
    logic [31:0] alu_result;
    logic        alu_overflow, alu_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_scheduler dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_unsigned(req0_unsigned), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_unsigned(req1_unsigned), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_ctrl(alu_ctrl),
        .alu_unsigned(alu_unsigned), .alu_freeze(alu_freeze),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ALU behaviour used by the stand-in: {overflow, zero, result}
    function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic uns);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            4'd0: r = 32'd0;
            4'd1: begin r = a + b; v = !uns && (a[31] == b[31]) && (r[31] != a[31]); end
            4'd2: begin r = a - b; v = !uns && (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3: r = a * b;
            4'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            default: r = a ^ b;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd3) return 3;
        if (op == 4'd4) return 8;
        return 1;
    endfunction

    // ALU stand-in: garbage while frozen so a capture at the wrong time shows
    logic [33:0] w_alu_ref;
    always_comb begin
        w_alu_ref = ref_alu(alu_ctrl, alu_inp1, alu_inp2, alu_unsigned);
        if (alu_freeze) begin
            alu_result   = 32'hBAD0_BAD0;
            alu_overflow = 1'b1;
            alu_zero     = 1'b0;
        end else begin
            alu_result   = w_alu_ref[31:0];
            alu_overflow = w_alu_ref[33];
            alu_zero     = w_alu_ref[32];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic u);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_unsigned = u;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_unsigned = u;
        end
    endtask

    // Reset with req0 valid held, checking every output's reset value
    task automatic do_reset();
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd1, 32'd1, 32'd1, 1'b0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_id, rsp_overflow, rsp_zero, alu_unsigned, alu_freeze, busy},
            7'b0000010);
        chk("rst_result", rsp_result, 0);
        chk("rst_alu", {alu_inp1, alu_inp2, alu_ctrl}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        uns;
        logic [31:0] exp_res;
        logic        exp_ovf, exp_zero;
        int          exp_lat;
    } vec_t;

    vec_t vt[8];

    // reference-model state for the random phase
    int          m_rem, m_retired;
    logic        m_pend, m_last, m_nop;
    logic        m_rsp_id, m_cur_id;
    logic [33:0] m_rsp, m_cur;
    logic        pv[2];
    logic [3:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    logic        pu[2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, frz, stale;
        int gseq[$];
        int rseq[$];

        vt[0] = '{0, 4'd1, 32'd2,          32'd5,          1'b0, 32'd7,          1'b0, 1'b0, 1};
        vt[1] = '{1, 4'd3, 32'd3,          32'd4,          1'b0, 32'd12,         1'b0, 1'b0, 3};
        vt[2] = '{1, 4'd4, 32'd12,         32'd4,          1'b1, 32'd3,          1'b0, 1'b0, 8};
        vt[3] = '{0, 4'd2, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b1, 1'b0, 1};
        vt[4] = '{0, 4'd0, 32'h1234,       32'h5678,       1'b0, 32'd0,          1'b0, 1'b1, 1};
        vt[5] = '{1, 4'd1, 32'hFFFF_FFFB,  32'd5,          1'b0, 32'd0,          1'b0, 1'b1, 1};
        vt[6] = '{0, 4'd1, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b1, 1'b0, 1};
        vt[7] = '{1, 4'd4, 32'd7,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 8};

        do_reset();

        // ---------------- directed single-requester vectors ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            set_req(vt[i].id, 1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].uns);
            rsp_ready = 1'b1;
            #1;
            chk("tbl_ready", (vt[i].id == 1) ? req1_ready : req0_ready, 1);
            chk("tbl_other_ready", (vt[i].id == 1) ? req0_ready : req1_ready, 0);
            chk("tbl_idle_freeze", alu_freeze, 1);
            @(posedge clock);
            #1;
            set_req(vt[i].id, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            chk("tbl_alu_ops", {alu_ctrl, alu_inp1, alu_inp2}, {vt[i].op, vt[i].a, vt[i].b});
            n = 0;
            frz = 0;
            while (!rsp_valid && n < 40) begin
                if (!alu_freeze) frz++;
                @(posedge clock);
                #1;
                n++;
            end
            chk("tbl_latency", n, vt[i].exp_lat);
            chk("tbl_freeze_low_cycles", frz, (vt[i].op == 4'd0) ? 0 : vt[i].exp_lat);
            chk("tbl_result", rsp_result, vt[i].exp_res);
            chk("tbl_flags", {rsp_overflow, rsp_zero}, {vt[i].exp_ovf, vt[i].exp_zero});
            chk("tbl_id", rsp_id, vt[i].id);
            @(posedge clock);
            #1;
            chk("tbl_busy_after", {busy, rsp_valid}, 2'b00);
        end

        // ---------------- both requesters contending ----------------
        do_reset();
        @(negedge clock);
        set_req(0, 1'b1, 4'd1, 32'd10, 32'd1, 1'b0);
        set_req(1, 1'b1, 4'd1, 32'd20, 32'd2, 1'b0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && (gseq.size() < 4 || rseq.size() < 4); c++) begin
            #1;
            if (req0_ready && req1_ready) chk("rr_one_hot", 2'b11, 2'b01);
            if (req0_ready) gseq.push_back(0);
            if (req1_ready) gseq.push_back(1);
            if (rsp_valid) begin
                rseq.push_back(int'(rsp_id));
                chk("rr_result", rsp_result, rsp_id ? 32'd22 : 32'd11);
            end
            @(negedge clock);
        end
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("rr_grant_count", (gseq.size() >= 4), 1);
        chk("rr_rsp_count", (rseq.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
            if (k < gseq.size()) chk("rr_grant_order", gseq[k], k % 2);
            if (k < rseq.size()) chk("rr_rsp_order", rseq[k], k % 2);
        end
        repeat (3) @(negedge clock);

        // ---------------- response stall with overflowing SUB ----------------
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd2, 32'h8000_0000, 32'd1, 1'b0);
        #1;
        chk("stall_accept", req0_ready, 1);
        @(posedge clock);
        #1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b1, 4'd1, 32'd1, 32'd1, 1'b0);
        @(posedge clock);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            chk("stall_rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_zero}, 4'b1010);
            chk("stall_result", rsp_result, 32'h7FFF_FFFF);
            chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
            chk("stall_freeze", alu_freeze, 1);
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        #1;
        chk("stall_retire_accept", req1_ready, 1);
        @(posedge clock);
        #1;
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("stall_next_exec", {busy, rsp_valid, alu_freeze}, 3'b100);
        @(posedge clock);
        #1;
        chk("stall_next_rsp", {rsp_valid, rsp_id}, 2'b11);
        chk("stall_next_result", rsp_result, 32'd2);

        // ---------------- reset in the middle of a DIV ----------------
        @(negedge clock);
        set_req(0, 1'b1, 4'd4, 32'd100, 32'd3, 1'b1);
        @(posedge clock);
        #1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (4) @(posedge clock);
        #3;
        set_req(1, 1'b1, 4'd1, 32'd1, 32'd1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", {rsp_valid, busy, alu_freeze, req0_ready, req1_ready}, 5'b00100);
        chk("mid_rst_alu", {alu_inp1, alu_inp2, alu_ctrl, alu_unsigned}, 0);
        chk("mid_rst_rsp", {rsp_result, rsp_id, rsp_overflow, rsp_zero}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        reset_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            #1;
            if (rsp_valid || busy) stale++;
        end
        chk("mid_rst_no_stale", stale, 0);

        // ---------------- random traffic against reference model ----------------
        do_reset();
        m_rem = 0; m_pend = 1'b0; m_last = 1'b1; m_nop = 1'b0; m_retired = 0;
        m_rsp = '0; m_cur = '0; m_rsp_id = 1'b0; m_cur_id = 1'b0;
        for (int j = 0; j < 2; j++) begin
            pv[j] = 1'b0; pop[j] = 4'd0; pa[j] = 32'd0; pb[j] = 32'd0; pu[j] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic win, g0, g1;
            int   gid;
            @(negedge clock);
            for (int j = 0; j < 2; j++) begin
                if (!pv[j] && $urandom_range(0, 2) == 0) begin
                    pv[j]  = 1'b1;
                    pop[j] = 4'($urandom_range(0, 7));
                    pa[j]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
                    pb[j]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
                    pu[j]  = 1'($urandom_range(0, 1));
                end else if (pv[j] && $urandom_range(0, 24) == 0) begin
                    pv[j] = 1'b0;
                end
                set_req(j, pv[j], pop[j], pa[j], pb[j], pu[j]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            // expectations from the transaction rules
            win = (m_rem == 0) && (!m_pend || rsp_ready);
            g0  = win && pv[0] && (!pv[1] || m_last);
            g1  = win && pv[1] && (!pv[0] || !m_last);
            chk("rnd_ready", {req0_ready, req1_ready}, {g0, g1});
            chk("rnd_status", {rsp_valid, busy, alu_freeze},
                {m_pend, (m_rem != 0) || m_pend, (m_rem == 0) || m_nop});
            if (m_pend) chk("rnd_rsp", {rsp_id, rsp_overflow, rsp_zero, rsp_result}, {m_rsp_id, m_rsp});
            // advance the model across the coming edge
            if (m_pend && rsp_ready) begin
                m_pend = 1'b0;
                m_retired++;
            end
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_pend   = 1'b1;
                    m_rsp    = m_cur;
                    m_rsp_id = m_cur_id;
                end
            end
            if (g0 || g1) begin
                gid      = g1 ? 1 : 0;
                m_last   = g1;
                m_cur_id = g1;
                m_rem    = lat_of(pop[gid]);
                m_nop    = (pop[gid] == 4'd0);
                m_cur    = ref_alu(pop[gid], pa[gid], pb[gid], pu[gid]);
                pv[gid]  = 1'b0;
            end
        end
        chk("rnd_activity", (m_retired > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
